// File: rtl/affine_pkg.sv
// Shared definitions for the 6-tap 1/16-phase affine horizontal filter:
// controller states, per-phase tap signs and coefficient magnitudes.
package affine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RUN,
      ST_DRAIN
   } state_t;

   localparam int NTAPS      = 6;
   localparam int ACC_W      = 19;
   localparam int PHASE0_TAP = 2;
   localparam int MAG_W      = 7;

   // Bit k set means tap k is subtracted; the outer taps 1 and 4 carry the negative lobes
   localparam logic [NTAPS-1:0] TAP_SGN [16] = '{
      6'b000000, 6'b010010, 6'b010010, 6'b010010,
      6'b010010, 6'b010010, 6'b010010, 6'b010010,
      6'b010010, 6'b010010, 6'b010010, 6'b010010,
      6'b010010, 6'b010010, 6'b010010, 6'b010010
   };

   // Packed {tap5, tap4, tap3, tap2, tap1, tap0}; every row's signed sum is 64
   localparam logic [NTAPS*MAG_W-1:0] TAP_MAG [16] = '{
      {7'd0, 7'd0,  7'd0,  7'd64, 7'd0,  7'd0},
      {7'd1, 7'd2,  7'd4,  7'd63, 7'd3,  7'd1},
      {7'd1, 7'd3,  7'd8,  7'd62, 7'd5,  7'd1},
      {7'd1, 7'd4,  7'd13, 7'd60, 7'd8,  7'd2},
      {7'd1, 7'd5,  7'd17, 7'd58, 7'd10, 7'd3},
      {7'd2, 7'd8,  7'd26, 7'd52, 7'd11, 7'd3},
      {7'd3, 7'd10, 7'd31, 7'd47, 7'd9,  7'd2},
      {7'd3, 7'd10, 7'd34, 7'd45, 7'd11, 7'd3},
      {7'd3, 7'd11, 7'd40, 7'd40, 7'd11, 7'd3},
      {7'd3, 7'd11, 7'd45, 7'd34, 7'd10, 7'd3},
      {7'd2, 7'd9,  7'd47, 7'd31, 7'd10, 7'd3},
      {7'd3, 7'd11, 7'd52, 7'd26, 7'd8,  7'd2},
      {7'd3, 7'd10, 7'd58, 7'd17, 7'd5,  7'd1},
      {7'd2, 7'd8,  7'd60, 7'd13, 7'd4,  7'd1},
      {7'd1, 7'd5,  7'd62, 7'd8,  7'd3,  7'd1},
      {7'd1, 7'd3,  7'd63, 7'd4,  7'd2,  7'd1}
   };

   function automatic logic [MAG_W-1:0] tap_mag(input logic [3:0] phase, input int k);
      return TAP_MAG[phase][k*MAG_W +: MAG_W];
   endfunction

endpackage

// File: rtl/affine_tap_bank.sv
// Combinational tap bank: constant-coefficient products per tap selected by phase,
// signed and summed into the 19-bit accumulator. No state is held here.
module affine_tap_bank
   import affine_pkg::*;
#(
   parameter int IN_W  = 11,
   parameter int SHIFT = 6
)
(
   input  logic signed [IN_W-1:0]  win [NTAPS],
   input  logic        [3:0]       phase,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [ACC_W-1:0] ext  [NTAPS];
   logic signed [ACC_W-1:0] prod [NTAPS];

   // Phase 0 is the integer position, so the sum collapses to a scaled copy of tap 2
   always_comb begin
      for (int k = 0; k < NTAPS; k++) begin
         ext[k]  = {{(ACC_W-IN_W){win[k][IN_W-1]}}, win[k]};
         prod[k] = ext[k] * $signed(ACC_W'(tap_mag(phase, k)));
      end
      acc = '0;
      if (phase == 4'd0) begin
         acc = ext[PHASE0_TAP] <<< SHIFT;
      end else begin
         for (int k = 0; k < NTAPS; k++) begin
            acc = TAP_SGN[phase][k] ? (acc - prod[k]) : (acc + prod[k]);
         end
      end
   end

endmodule

// File: rtl/affine_hfilt_ctrl.sv
// Line sequencer for one horizontal affine interpolation row: fills the sample
// window, filters each new window, then rounds, saturates and hands results downstream.
module affine_hfilt_ctrl
   import affine_pkg::*;
#(
   parameter int IN_W   = 11,
   parameter int OUT_W  = 11,
   parameter int LINE_W = 16,
   parameter int SHIFT  = 6
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic        [3:0]       frac,
   output logic                    busy,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    line_done
);

   localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1 << (SHIFT-1));
   localparam logic signed [ACC_W-1:0] MAX_C = ACC_W'((1 << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] MIN_C = ACC_W'(-(1 << (OUT_W-1)));

   state_t                  state;
   logic signed [IN_W-1:0]  win     [NTAPS];
   logic signed [IN_W-1:0]  win_nxt [NTAPS];
   logic        [2:0]       fill_cnt;
   logic        [7:0]       run_cnt;
   logic        [3:0]       frac_q;
   logic                    accept;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] rnd;
   logic signed [ACC_W-1:0] shf;
   logic signed [OUT_W-1:0] res;

   assign busy     = (state != ST_IDLE);
   assign in_ready = (state == ST_FILL) | ((state == ST_RUN) & (~out_valid | out_ready));
   assign accept   = in_valid & in_ready;

   // The filter sees the window as it will be after this accept, so the result
   // can be registered in the same cycle the completing sample arrives
   always_comb begin
      for (int k = 0; k < NTAPS-1; k++) begin
         win_nxt[k] = win[k+1];
      end
      win_nxt[NTAPS-1] = in_data;
   end

   affine_tap_bank #(
      .IN_W  (IN_W),
      .SHIFT (SHIFT)
   ) u_taps (
      .win   (win_nxt),
      .phase (frac_q),
      .acc   (acc)
   );

   always_comb begin
      rnd = acc + RND_C;
      shf = rnd >>> SHIFT;
      if (shf > MAX_C) begin
         res = MAX_C[OUT_W-1:0];
      end else if (shf < MIN_C) begin
         res = MIN_C[OUT_W-1:0];
      end else begin
         res = shf[OUT_W-1:0];
      end
   end

   // A start arriving alongside line_done is dropped so lines never overlap the pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         for (int k = 0; k < NTAPS; k++) begin
            win[k] <= '0;
         end
         fill_cnt  <= '0;
         run_cnt   <= '0;
         frac_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         line_done <= 1'b0;
      end else begin
         line_done <= 1'b0;
         if (accept) begin
            for (int k = 0; k < NTAPS-1; k++) begin
               win[k] <= win[k+1];
            end
            win[NTAPS-1] <= in_data;
         end
         if (accept && (state == ST_RUN)) begin
            out_data  <= res;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (start && !line_done) begin
                  state    <= ST_FILL;
                  frac_q   <= frac;
                  fill_cnt <= '0;
                  run_cnt  <= '0;
               end
            end
            ST_FILL: begin
               if (accept) begin
                  if (fill_cnt == 3'd4) begin
                     fill_cnt <= '0;
                     state    <= ST_RUN;
                  end else begin
                     fill_cnt <= fill_cnt + 3'd1;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (run_cnt == 8'(LINE_W-1)) begin
                     run_cnt <= '0;
                     state   <= ST_DRAIN;
                  end else begin
                     run_cnt <= run_cnt + 8'd1;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_valid && out_ready) begin
                  state     <= ST_IDLE;
                  line_done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_affine_hfilt_ctrl.sv
// Bench for affine_hfilt_ctrl: directed lines checked against an integer filter
// model through an expected-output queue, plus literal pins on the model.
module tb_affine_hfilt_ctrl;

   localparam int LINE_W = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic        [3:0]  frac = 4'd0;
   logic               in_valid = 1'b0;
   logic signed [10:0] in_data = '0;
   logic               out_ready = 1'b0;
   logic               busy;
   logic               in_ready;
   logic               out_valid;
   logic signed [10:0] out_data;
   logic               line_done;

   int checks = 0;
   int errors = 0;
   int expq[$];
   int line_smp[$];
   int pop_cycles[$];
   int pop_total = 0;
   int done_total = 0;
   int cyc = 0;

   // Signed 6-tap coefficients, tap 0 first, one row per 1/16 phase
   int coef [16][6] = '{
      '{0,   0, 64,  0,   0, 0}, '{1,  -3, 63,  4,  -2, 1},
      '{1,  -5, 62,  8,  -3, 1}, '{2,  -8, 60, 13,  -4, 1},
      '{3, -10, 58, 17,  -5, 1}, '{3, -11, 52, 26,  -8, 2},
      '{2,  -9, 47, 31, -10, 3}, '{3, -11, 45, 34, -10, 3},
      '{3, -11, 40, 40, -11, 3}, '{3, -10, 34, 45, -11, 3},
      '{3, -10, 31, 47,  -9, 2}, '{2,  -8, 26, 52, -11, 3},
      '{1,  -5, 17, 58, -10, 3}, '{1,  -4, 13, 60,  -8, 2},
      '{1,  -3,  8, 62,  -5, 1}, '{1,  -2,  4, 63,  -3, 1}
   };

   affine_hfilt_ctrl #(
      .IN_W   (11),
      .OUT_W  (11),
      .LINE_W (LINE_W),
      .SHIFT  (6)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frac      (frac),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .line_done (line_done)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int filt(input int w[6], input int p);
      int a = 0;
      int r;
      int q;
      for (int k = 0; k < 6; k++) a += coef[p][k] * w[k];
      r = a + 32;
      q = (r >= 0) ? r / 64 : -((-r + 63) / 64);
      if (q > 1023) q = 1023;
      if (q < -1024) q = -1024;
      return q;
   endfunction

   function automatic int filt_at(input int i, input int p);
      int w[6];
      for (int k = 0; k < 6; k++) w[k] = line_smp[i+k];
      return filt(w, p);
   endfunction

   // Single compare process: every handshake is checked against the expected queue
   initial begin
      bit held_v = 1'b0;
      bit prev_ld = 1'b0;
      int held_d = 0;
      int e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            held_v  = 1'b0;
            prev_ld = 1'b0;
         end else begin
            if (held_v) check_output("hold_data", int'(out_data), held_d);
            if (out_valid && !out_ready) check_output("in_ready_stall", int'(in_ready), 0);
            held_v = out_valid && !out_ready;
            held_d = int'(out_data);
            if (out_valid && out_ready) begin
               e = (expq.size() > 0) ? expq.pop_front() : 99999;
               check_output("out_data", int'(out_data), e);
               pop_cycles.push_back(cyc);
               pop_total++;
            end
            if (line_done) begin
               done_total++;
               check_output("done_pulse_width", int'(prev_ld), 0);
               check_output("done_pending_outputs", expq.size(), 0);
            end
            prev_ld = line_done;
         end
      end
   end

   task automatic do_abort();
      int done0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      start = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_output("abort_busy", int'(busy), 0);
      check_output("abort_in_ready", int'(in_ready), 0);
      check_output("abort_out_valid", int'(out_valid), 0);
      check_output("abort_line_done", int'(line_done), 0);
      check_output("abort_out_data", int'(out_data), 0);
      expq.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      done0 = done_total;
      repeat (4) begin
         @(negedge clk);
         check_output("abort_idle", int'(busy), 0);
      end
      #1;
      check_output("abort_no_done", done_total - done0, 0);
   endtask

   task automatic apply_stimulus(input int f, input bit noise, input int bp_at, input int abort_at);
      int n = line_smp.size();
      int idx = 0;
      int bp_left = 3;
      int pop0;
      int done0;
      int guard;
      bit acc;
      bit finished = 1'b0;
      bit aborted = 1'b0;
      expq.delete();
      pop_cycles.delete();
      for (int i = 0; i < LINE_W; i++) expq.push_back(filt_at(i, f));
      pop0 = pop_total;
      done0 = done_total;
      @(posedge clk);
      #1;
      start = 1'b1;
      frac = 4'(f);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      start = noise;
      if (noise) frac = ~4'(f);
      in_valid = (idx < n);
      in_data = 11'(line_smp[idx]);
      for (guard = 0; guard < 1000 && !finished && !aborted; guard++) begin
         @(negedge clk);
         if (line_done) begin
            finished = 1'b1;
         end else begin
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (abort_at >= 0 && (pop_total - pop0) == abort_at) begin
               do_abort();
               aborted = 1'b1;
            end else begin
               in_valid = (idx < n);
               in_data = (idx < n) ? 11'(line_smp[idx]) : '0;
               if (bp_at >= 0 && (pop_total - pop0) == bp_at && bp_left > 0) begin
                  out_ready = 1'b0;
                  bp_left--;
               end else begin
                  out_ready = 1'b1;
               end
               if (noise) frac = 4'($urandom_range(15));
            end
         end
      end
      #1;
      if (!aborted) begin
         check_output("line_finished", int'(finished), 1);
         check_output("line_outputs", pop_total - pop0, LINE_W);
         check_output("line_done_count", done_total - done0, 1);
         check_output("samples_used", idx, LINE_W + 5);
         if (bp_at < 0) begin
            check_output("throughput",
               (pop_cycles.size() == LINE_W) ? pop_cycles[LINE_W-1] - pop_cycles[0] : -1,
               LINE_W - 1);
         end
         if (noise) begin
            @(posedge clk);
            #1;
            check_output("start_with_done_ignored", int'(busy), 0);
            start = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w6[6];
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_busy", int'(busy), 0);
      check_output("reset_in_ready", int'(in_ready), 0);
      check_output("reset_out_valid", int'(out_valid), 0);
      check_output("reset_line_done", int'(line_done), 0);
      check_output("reset_out_data", int'(out_data), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      w6 = '{0, 0, -1, 0, 0, 0};
      check_output("pin_neg_round", filt(w6, 1), -1);

      $display("[TB] constant line, frac 7");
      line_smp.delete();
      for (int i = 0; i < LINE_W + 5; i++) line_smp.push_back(100);
      check_output("pin_const", filt_at(0, 7), 100);
      apply_stimulus(7, 1'b0, -1, -1);

      $display("[TB] phase 0 ramp");
      line_smp.delete();
      for (int i = 0; i < LINE_W + 5; i++) line_smp.push_back(i);
      check_output("pin_ramp_first", filt_at(0, 0), 2);
      check_output("pin_ramp_last", filt_at(LINE_W - 1, 0), 17);
      apply_stimulus(0, 1'b0, -1, -1);

      $display("[TB] backpressure, frac 5");
      line_smp.delete();
      for (int i = 0; i < LINE_W + 5; i++) line_smp.push_back(((i * 37) % 200) - 100);
      apply_stimulus(5, 1'b0, 4, -1);

      $display("[TB] saturation, frac 8");
      line_smp.delete();
      for (int i = 0; i < LINE_W + 5; i++) line_smp.push_back(((i / 2) % 2 == 0) ? 1023 : -1024);
      check_output("pin_sat_low", filt_at(0, 8), -1024);
      check_output("pin_sat_high", filt_at(2, 8), 1023);
      apply_stimulus(8, 1'b0, -1, -1);

      $display("[TB] reset mid-line");
      line_smp.delete();
      for (int i = 0; i < LINE_W + 5; i++) line_smp.push_back(i * 10 - 50);
      apply_stimulus(3, 1'b0, -1, 5);
      apply_stimulus(9, 1'b0, -1, -1);

      $display("[TB] busy start/frac noise, back-to-back");
      line_smp.delete();
      for (int i = 0; i < LINE_W + 5; i++) line_smp.push_back(int'($urandom_range(2047)) - 1024);
      apply_stimulus(11, 1'b1, -1, -1);
      line_smp.delete();
      for (int i = 0; i < LINE_W + 5; i++) line_smp.push_back(int'($urandom_range(2047)) - 1024);
      apply_stimulus(13, 1'b1, -1, -1);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
